// File: rtl/retospect_lif_neuron.sv
// retospect_lif_neuron: leaky integrate-and-fire cell with serial config chain, threshold and refractory period
module retospect_lif_neuron #(
    parameter int N_DEND   = 4,
    parameter int W_BITS   = 3,
    parameter int P_BITS   = 4,
    parameter int REF_BITS = 2,
    parameter int SEL_BITS = 3,
    parameter bit SIGNED_W = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     reset_nn,
    input  logic                     config_en,
    input  logic                     bs_in,
    output logic                     bs_out,
    input  logic [2**SEL_BITS-1:0]   clockbus,
    input  logic [N_DEND-1:0]        dendrite,
    output logic                     axon,
    output logic [P_BITS-1:0]        potential
);
    localparam int L = N_DEND*W_BITS + P_BITS + REF_BITS + SEL_BITS;
    localparam int S = P_BITS + W_BITS + $clog2(N_DEND) + 1;
    localparam int T = N_DEND*W_BITS;

    logic [L-1:0]           cfg;
    logic [REF_BITS-1:0]    refr_cnt;
    logic [P_BITS-1:0]      thr, leaked, clamped;
    logic [REF_BITS-1:0]    ref_len;
    logic [SEL_BITS-1:0]    sel;
    logic signed [S-1:0]    sum;
    logic                   fire;

    assign thr     = cfg[T +: P_BITS];
    assign ref_len = cfg[T+P_BITS +: REF_BITS];
    assign sel     = cfg[T+P_BITS+REF_BITS +: SEL_BITS];
    assign bs_out  = cfg[0];
    assign leaked  = clockbus[sel] ? potential >> 1 : potential;

    // sum is wide enough that no combination of weights can wrap before clamping
    always_comb begin
        sum = $signed({{(S-P_BITS){1'b0}}, leaked});
        for (int i = 0; i < N_DEND; i++)
            if (dendrite[i])
                sum = sum + $signed({{(S-W_BITS){SIGNED_W && cfg[i*W_BITS+W_BITS-1]}}, cfg[i*W_BITS +: W_BITS]});
    end

    assign clamped = sum[S-1] ? '0 : (|sum[S-2:P_BITS] ? '1 : sum[P_BITS-1:0]);
    assign fire    = clamped >= thr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg       <= '0;
            potential <= '0;
            refr_cnt  <= '0;
            axon      <= 1'b0;
        end else if (reset_nn) begin
            potential <= '0;
            refr_cnt  <= '0;
            axon      <= 1'b0;
        end else if (config_en) begin
            cfg  <= {bs_in, cfg[L-1:1]};
            axon <= 1'b0;
        end else if (refr_cnt != '0) begin
            refr_cnt  <= refr_cnt - REF_BITS'(1);
            potential <= '0;
            axon      <= 1'b0;
        end else begin
            axon      <= fire;
            potential <= fire ? '0 : clamped;
            refr_cnt  <= fire ? ref_len : '0;
        end
    end
endmodule
